// File: rtl/dh_pkg.sv
// Shared defaults and types for the R2 key-exchange datapath.
package dh_pkg;

    localparam int unsigned W_DEF  = 32;
    localparam int unsigned DW_DEF = 4;

    typedef enum logic [2:0] {IDLE, RED, SQR, MUL, FIN, ERR} dec_state_t;

    localparam logic [W_DEF-1:0] ONE = {{(W_DEF-1){1'b0}}, 1'b1};

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved MSB-first modular multiplier: y = a*b mod p in W cycles, b < p required.
// The go cycle performs the first step, so back-to-back products have no idle cycles.
module mod_mul_serial
    import dh_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         rdy,
    output logic [W-1:0] y
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_in, a_in, b_in, p_in;
    logic [W:0]    dbl, dbl_r, sum, sum_r;

    always_comb begin
        acc_in = go ? '0 : acc_q;
        a_in   = go ? a  : a_q;
        b_in   = go ? b  : b_q;
        p_in   = go ? p  : p_q;

        // acc < p keeps every intermediate within W+1 bits
        dbl   = {acc_in, 1'b0};
        dbl_r = (dbl >= {1'b0, p_in}) ? dbl - {1'b0, p_in} : dbl;
        sum   = dbl_r + {1'b0, b_in & {W{a_in[W-1]}}};
        sum_r = (sum >= {1'b0, p_in}) ? sum - {1'b0, p_in} : sum;

        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        rdy   = 1'b0;
        y     = sum_r[W-1:0];

        if (go) begin
            a_d   = a << 1;
            b_d   = b;
            p_d   = p;
            acc_d = sum_r[W-1:0];
            cnt_d = CW'(W - 1);
            rdy   = (W == 1);
        end else if (cnt_q != '0) begin
            a_d   = a_q << 1;
            acc_d = sum_r[W-1:0];
            cnt_d = cnt_q - 1'b1;
            rdy   = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decryption_r2.sv
// R2 decryptor: m = c1 ^ (base**x mod p)[DW-1:0] via constant-time square-and-multiply.
// Define DEC_KEY_OUT_EN to expose the full shared key on output key.
module decryption_r2
    import dh_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  p,
    input  logic [DW-1:0] c1,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] m,
`ifdef DEC_KEY_OUT_EN
    output logic [W-1:0]  key,
`endif
    output logic          err
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] OneW = {{(W-1){1'b0}}, 1'b1};

    dec_state_t    state_q, state_d;
    logic [W-1:0]  base_q, base_d, x_q, x_d, p_q, p_d, bred_q, bred_d, r_q, r_d;
    logic [DW-1:0] c1_q, c1_d, m_q, m_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [W-1:0]  mm_a, mm_b, mm_y;
    logic          mm_rdy;
`ifdef DEC_KEY_OUT_EN
    logic [W-1:0]  key_q, key_d;
`endif

    mod_mul_serial #(
        .W (W)
    ) u_mm (
        .clk (clk),
        .rst (rst),
        .go  (go_q),
        .a   (mm_a),
        .b   (mm_b),
        .p   (p_q),
        .rdy (mm_rdy),
        .y   (mm_y)
    );

    // Operands are only sampled by the multiplier in the go cycle
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            RED:     begin mm_a = base_q; mm_b = OneW;   end
            SQR:     begin mm_a = r_q;    mm_b = r_q;    end
            MUL:     begin mm_a = r_q;    mm_b = bred_q; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        x_d     = x_q;
        p_d     = p_q;
        c1_d    = c1_q;
        bred_d  = bred_q;
        r_d     = r_q;
        idx_d   = idx_q;
        m_d     = m_q;
        err_d   = err_q;
        busy_d  = busy_q;
        go_d    = 1'b0;
        done_d  = 1'b0;
`ifdef DEC_KEY_OUT_EN
        key_d   = key_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base;
                    x_d    = x;
                    p_d    = p;
                    c1_d   = c1;
                    r_d    = OneW;
                    idx_d  = IW'(W - 1);
                    busy_d = 1'b1;
                    if (p < W'(2)) begin
                        state_d = ERR;
                    end else begin
                        state_d = RED;
                        go_d    = 1'b1;
                    end
                end
            end
            RED: begin
                if (mm_rdy) begin
                    bred_d  = mm_y;
                    state_d = SQR;
                    go_d    = 1'b1;
                end
            end
            SQR: begin
                if (mm_rdy) begin
                    r_d     = mm_y;
                    state_d = MUL;
                    go_d    = 1'b1;
                end
            end
            MUL: begin
                // Product is always computed; the exponent bit only selects it
                if (mm_rdy) begin
                    if (x_q[idx_q]) r_d = mm_y;
                    if (idx_q == '0) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQR;
                        go_d    = 1'b1;
                    end
                end
            end
            FIN: begin
                m_d     = c1_q ^ r_q[DW-1:0];
                err_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef DEC_KEY_OUT_EN
                key_d   = r_q;
`endif
            end
            ERR: begin
                m_d     = c1_q;
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef DEC_KEY_OUT_EN
                key_d   = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            x_q     <= '0;
            p_q     <= '0;
            c1_q    <= '0;
            bred_q  <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            m_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEC_KEY_OUT_EN
            key_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            x_q     <= x_d;
            p_q     <= p_d;
            c1_q    <= c1_d;
            bred_q  <= bred_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
            done_q  <= done_d;
`ifdef DEC_KEY_OUT_EN
            key_q   <= key_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign m    = m_q;
    assign err  = err_q;
`ifdef DEC_KEY_OUT_EN
    assign key  = key_q;
`endif

endmodule
